// File: rtl/button_event_ctrl.sv
// Debounced button event controller: sample-tick prescaler, per-button shift
// debouncers, round-robin request arbiter and a small valid/ready event FIFO.
module button_event_ctrl #(
  parameter int N_BTN      = 4,
  parameter int ID_W       = 2,
  parameter int CLK_DIV    = 200000,
  parameter int DB_LEN     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic             sample_tick,
  output logic             evt_overflow
);

  localparam int PRE_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [DB_LEN-1:0] MATCH_PAT = {1'b0, {(DB_LEN-1){1'b1}}};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [PRE_W-1:0]  presc;
  logic [N_BTN-1:0]  sync_p0, sync_p1;
  logic [DB_LEN-1:0] shreg [N_BTN];
  logic              tick_p1;
  logic [N_BTN-1:0]  match_p1;
  logic [N_BTN-1:0]  pending;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_idx;
  logic [N_BTN-1:0]  grant_mask;
  logic [ID_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_full;
  logic              push, pop;

  // Prescaler: one-cycle tick on the last count of each sample period
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == PRE_W'(CLK_DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign sample_tick = (presc == PRE_W'(CLK_DIV - 1));

  // Stage p0/p1: two-flop synchroniser, then sample shift on tick
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      tick_p1 <= 1'b0;
      for (int i = 0; i < N_BTN; i++) shreg[i] <= '0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
      tick_p1 <= sample_tick;
      if (sample_tick) begin
        for (int i = 0; i < N_BTN; i++) shreg[i] <= {shreg[i][DB_LEN-2:0], sync_p1[i]};
      end
    end
  end

  // Match only in the cycle after a shift so a held pattern fires once
  always_comb begin
    match_p1 = '0;
    for (int i = 0; i < N_BTN; i++) match_p1[i] = tick_p1 && (shreg[i] == MATCH_PAT);
  end

  assign fifo_full = (fifo_cnt == FCNT_W'(FIFO_DEPTH));

  // Round-robin scan starting at rr_ptr; blocked entirely while the FIFO is full
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!fifo_full) begin
      for (int off = 0; off < N_BTN; off++) begin
        idx = (int'(rr_ptr) + off) % N_BTN;
        if (!grant_vld && pending[idx]) begin
          grant_vld = 1'b1;
          grant_idx = ID_W'(idx);
        end
      end
    end
  end

  assign grant_mask = grant_vld ? (N_BTN'(1) << grant_idx) : '0;

  // Stage p2: pending requests, collision flag, arbiter pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      pending      <= '0;
      rr_ptr       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pending <= (pending & ~grant_mask) | (match_p1 & ~pending);
      if (|(match_p1 & pending)) evt_overflow <= 1'b1;
      if (grant_vld) begin
        rr_ptr <= (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign push = grant_vld;
  assign pop  = evt_valid && evt_ready;

  // Event FIFO: control state is reset, storage is not
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= grant_idx;
  end

  assign evt_valid = (fifo_cnt != '0);
  assign evt_id    = evt_valid ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl with a short prescaler and debounce length.
module tb_button_event_ctrl;

  localparam int N_BTN      = 4;
  localparam int ID_W       = 2;
  localparam int CLK_DIV    = 4;
  localparam int DB_LEN     = 4;
  localparam int FIFO_DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btn_in = '0;
  logic             evt_ready = 1'b0;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;
  logic             sample_tick;
  logic             evt_overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];

  button_event_ctrl #(
    .N_BTN(N_BTN), .ID_W(ID_W), .CLK_DIV(CLK_DIV), .DB_LEN(DB_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_id(evt_id), .sample_tick(sample_tick), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every accepted event must match the next expected id
  always @(negedge clk) begin
    int e;
    if (!reset && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL evt_unexpected: got id=%0d at cycle %0d, required no event", evt_id, cyc);
      end else begin
        e = exp_q.pop_front();
        if (evt_id !== ID_W'(e)) begin
          failures++;
          $display("FAIL evt_order: got id=%0d, required id=%0d", evt_id, e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  // Returns just after the clock edge that ends a sample_tick cycle
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_tick && n < 2 * CLK_DIV);
    if (!sample_tick) begin
      checks++;
      failures++;
      $display("FAIL tick_timeout: no sample_tick after %0d cycles, required within %0d", n, CLK_DIV);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    btn_in = '0;
    evt_ready = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_in = '0;
    evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({evt_valid, evt_id, sample_tick, evt_overflow} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b id=%0d tick=%b ovf=%b, required all 0",
               evt_valid, evt_id, sample_tick, evt_overflow);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checks++;
      if (sample_tick !== (n % CLK_DIV == 0) || evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_tick: cycle %0d got tick=%b valid=%b, required tick=%b valid=0",
                 n, sample_tick, evt_valid, (n % CLK_DIV == 0));
      end
    end
  endtask

  task automatic test_clean_press();
    int tn, t3, n_ev;
    logic exp_v;
    tn = 0; t3 = -100; n_ev = 0;
    evt_ready = 1'b1;
    wait_tick();
    btn_in[2] = 1'b1;
    exp_q.push_back(2);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (sample_tick) begin
        tn++;
        if (tn == DB_LEN - 1) t3 = cyc;
      end
      // valid follows the second edge after the completing tick edge
      exp_v = (cyc == t3 + 3);
      if (evt_valid) n_ev++;
      checks++;
      if (evt_valid !== exp_v) begin
        failures++;
        $display("FAIL clean_valid: cycle %0d got valid=%b, required %b", cyc, evt_valid, exp_v);
      end
    end
    checks++;
    if (n_ev !== 1) begin
      failures++;
      $display("FAIL clean_count: got %0d events, required 1", n_ev);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL clean_drain: got %0d events outstanding, required 0", exp_q.size());
    end
    wait_tick();
    btn_in[2] = 1'b0;
    hold_ticks(DB_LEN + 1);
  endtask

  task automatic test_bounce();
    int vals[9] = '{1, 0, 1, 0, 1, 1, 1, 1, 1};
    int tn, t7, n;
    logic done, exp_v;
    tn = 0; t7 = -100;
    evt_ready = 1'b1;
    wait_tick();
    exp_q.push_back(1);
    for (int j = 0; j < 9; j++) begin
      btn_in[1] = (vals[j] != 0);
      n = 0;
      done = 1'b0;
      while (!done && n < 2 * CLK_DIV) begin
        @(negedge clk);
        n++;
        if (sample_tick) begin
          tn++;
          if (tn == 7) t7 = cyc;
          done = 1'b1;
        end
        exp_v = (cyc == t7 + 3);
        checks++;
        if (evt_valid !== exp_v) begin
          failures++;
          $display("FAIL bounce_valid: cycle %0d step %0d got valid=%b, required %b", cyc, j, evt_valid, exp_v);
        end
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL bounce_tick_timeout: step %0d got no tick, required one within %0d cycles", j, CLK_DIV);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL bounce_drain: got %0d events outstanding, required 0", exp_q.size());
    end
    btn_in[1] = 1'b0;
    hold_ticks(DB_LEN + 1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    evt_ready = 1'b0;
    wait_tick();
    btn_in = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    hold_ticks(DB_LEN - 1);
    repeat (6) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
        failures++;
        $display("FAIL sim_head_stable: got valid=%b id=%0d, required valid=1 id=0", evt_valid, evt_id);
      end
    end
    @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL sim_drain: got %0d outstanding valid=%b, required 0 and 0", exp_q.size(), evt_valid);
    end
    wait_tick();
    btn_in = '0;
    evt_ready = 1'b0;
    hold_ticks(DB_LEN);
    btn_in = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    hold_ticks(DB_LEN - 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      failures++;
      $display("FAIL sim_all_head: got valid=%b id=%0d, required valid=1 id=0", evt_valid, evt_id);
    end
    @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sim_all_drain: got %0d events outstanding, required 0", exp_q.size());
    end
    wait_tick();
    btn_in = '0;
    evt_ready = 1'b0;
    hold_ticks(DB_LEN);
  endtask

  task automatic test_full_overflow();
    do_reset();
    evt_ready = 1'b0;
    wait_tick();
    btn_in = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    hold_ticks(DB_LEN - 1);
    repeat (6) @(posedge clk);
    wait_tick();
    btn_in = '0;
    hold_ticks(DB_LEN);
    // FIFO is full: these two stay pending
    btn_in = 4'b1100;
    exp_q.push_back(2); exp_q.push_back(3);
    hold_ticks(DB_LEN - 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (evt_overflow !== 1'b0 || evt_valid !== 1'b1 || evt_id !== 2'd0) begin
      failures++;
      $display("FAIL full_pending: got ovf=%b valid=%b id=%0d, required ovf=0 valid=1 id=0",
               evt_overflow, evt_valid, evt_id);
    end
    wait_tick();
    btn_in = '0;
    hold_ticks(DB_LEN);
    btn_in = 4'b0100;
    hold_ticks(DB_LEN - 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (evt_overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: got ovf=%b, required 1", evt_overflow);
    end
    @(posedge clk);
    #1 evt_ready = 1'b1;
    repeat (16) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0 || evt_valid !== 1'b0 || evt_overflow !== 1'b1) begin
      failures++;
      $display("FAIL full_drain: got %0d outstanding valid=%b ovf=%b, required 0 0 1",
               exp_q.size(), evt_valid, evt_overflow);
    end
    evt_ready = 1'b0;
    wait_tick();
    btn_in = '0;
    hold_ticks(DB_LEN);
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    wait_tick();
    btn_in = 4'b0111;
    hold_ticks(DB_LEN - 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_overflow !== 1'b1) begin
      failures++;
      $display("FAIL mid_prefill: got valid=%b ovf=%b, required 1 1", evt_valid, evt_overflow);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    btn_in = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0 || evt_overflow !== 1'b0 || sample_tick !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got valid=%b ovf=%b tick=%b, required 0 0 0",
               evt_valid, evt_overflow, sample_tick);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      checks++;
      if (sample_tick !== (n % CLK_DIV == 0) || evt_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_restart: cycle %0d got tick=%b valid=%b, required tick=%b valid=0",
                 n, sample_tick, evt_valid, (n % CLK_DIV == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_full_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
